// File: rtl/instr_decoder.sv
// Instruction front end: decodes raw words into a one-hot opcode vector and
// holds them in a two-entry buffer, with an optional stall on illegal opcodes.
module instr_decoder #(
   parameter int INSTR_W         = 16,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [63:0]        onehot,
   output logic [INSTR_W-7:0] operand,
   output logic               illegal,
   output logic               halted,
   input  logic               clr_halt,
   output logic [7:0]         illegal_cnt
);

   localparam int OP_W = INSTR_W - 6;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready is a function of registered state only.
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t          state;
   logic [63:0]     oh_mem  [2];
   logic [OP_W-1:0] op_mem  [2];
   logic            ill_mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;

   logic            accept;
   logic            pop;
   logic            pop_illegal;
   logic [5:0]      opc;
   logic [63:0]     wr_onehot;
   logic            wr_illegal;

   assign opc = instr[INSTR_W-1 -: 6];

   // Decoding happens on the way in so the head entry is ready-made.
   always_comb begin
      wr_onehot  = '0;
      wr_illegal = 1'b1;
      case (opc)
         6'd4, 6'd25, 6'd12, 6'd13, 6'd14, 6'd59: begin
            wr_onehot  = 64'd1 << opc;
            wr_illegal = 1'b0;
         end
         default: begin
            wr_onehot  = '0;
            wr_illegal = 1'b1;
         end
      endcase
   end

   assign instr_ready = (count != 2'd2) && (state == RUN);
   assign dec_valid   = (count != 2'd0);
   assign accept      = instr_valid && instr_ready;
   assign pop         = dec_valid && dec_ready;
   assign pop_illegal = pop && ill_mem[rd_ptr];

   assign onehot  = dec_valid ? oh_mem[rd_ptr] : 64'd0;
   assign operand = dec_valid ? op_mem[rd_ptr] : '0;
   assign illegal = dec_valid && ill_mem[rd_ptr];
   assign halted  = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         oh_mem[0]  <= '0;
         oh_mem[1]  <= '0;
         op_mem[0]  <= '0;
         op_mem[1]  <= '0;
         ill_mem[0] <= 1'b0;
         ill_mem[1] <= 1'b0;
      end else begin
         if (accept) begin
            oh_mem[wr_ptr]  <= wr_onehot;
            op_mem[wr_ptr]  <= instr[OP_W-1:0];
            ill_mem[wr_ptr] <= wr_illegal;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (accept && !pop) begin
            count <= count + 2'd1;
         end else if (pop && !accept) begin
            count <= count - 2'd1;
         end
      end
   end

   // An illegal pop outranks a simultaneous clr_halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (pop_illegal && HALT_ON_ILLEGAL) begin
                  state <= HALT;
               end
            end
            HALT: begin
               if (clr_halt && !pop_illegal) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt <= 8'd0;
      end else if (pop_illegal && (illegal_cnt != 8'd255)) begin
         illegal_cnt <= illegal_cnt + 8'd1;
      end
   end

endmodule
